ram_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 256x8 RAM between up to NREQ requesters. Each requester presents a read or write. The arbiter grants one at a time, drives the RAM address, RWn and write-data lines, and returns read data with a one-cycle Done strobe. It sits between the test/host masters and the RAM; the top level wires its RAM-side ports onto the DataBus/CtrlBus.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter.
//   arb_state_t : FSM encoding (IDLE, ISSUE, COMPLETE)
//   DEF_AW/DEF_DW : default RAM address/data widths
//   idx_w(n)    : bits needed to index n requesters (at least 1)
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : eligible request vector (already masked by the caller)
//   ptr   : index where the search starts; wraps past N-1 back to 0
//   found : some request is set
//   win   : index of the first set request at or after ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] win
);

  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      // explicit wrap keeps non-power-of-two N correct
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters.
//   Clk, Rst         : clock, synchronous active-high reset
//   Req/Wr/Addr/WData: per-requester request, op (1=write), address, data
//   Gnt              : one-hot grant, high in ISSUE and COMPLETE
//   Done             : one-hot completion strobe (COMPLETE cycle)
//   RData            : read data, valid only in Done cycle of a read
//   RamAddr/RamWData/RamRWn/RamRData : RAM side (RWn 1=read)
// Each access takes ISSUE (RAM edge at its end) then COMPLETE (result
// visible). Arbitration happens in IDLE and in COMPLETE, so accesses from
// different requesters can chain every 2 cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ-1:0]          Wr,
  input  logic [NREQ-1:0][AW-1:0]  Addr,
  input  logic [NREQ-1:0][DW-1:0]  WData,
  output logic [NREQ-1:0]          Gnt,
  output logic [NREQ-1:0]          Done,
  output logic [DW-1:0]            RData,
  output logic [AW-1:0]            RamAddr,
  output logic [DW-1:0]            RamWData,
  output logic                     RamRWn,
  input  logic [DW-1:0]            RamRData
);

  localparam int IW = idx_w(NREQ);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] cur, ptr, win;
  logic          found;
  logic [NREQ-1:0] elig;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  // The just-completed requester is masked for one arbitration so that a
  // held Req is treated as a fresh request one cycle later.
  always_comb begin
    elig = '0;
    if (state == IDLE) begin
      elig = Req;
    end else if (state == COMPLETE) begin
      elig      = Req;
      elig[cur] = 1'b0;
    end
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .found (found),
    .win   (win)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (found) state_nxt = ISSUE;
      ISSUE:    state_nxt = COMPLETE;
      COMPLETE: state_nxt = found ? ISSUE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cur     <= '0;
      ptr     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      // found is only ever set in IDLE/COMPLETE (elig is zero in ISSUE)
      if (found) begin
        cur     <= win;
        ptr     <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        wr_q    <= Wr[win];
        addr_q  <= Addr[win];
        wdata_q <= WData[win];
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    Gnt      = '0;
    Done     = '0;
    RData    = '0;
    RamRWn   = 1'b1;
    RamAddr  = '0;
    RamWData = '0;
    if (state != IDLE) Gnt[cur] = 1'b1;
    if (state == ISSUE) begin
      RamRWn   = ~wr_q;
      RamAddr  = addr_q;
      RamWData = wdata_q;
    end
    if (state == COMPLETE) begin
      Done[cur] = 1'b1;
      if (!wr_q) RData = RamRData;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a random
// run checked against a transaction-timeline reference model.
module tb_ram_arbiter;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [3:0]      Req, Wr, Gnt, Done;
  logic [3:0][7:0] Addr, WData;
  logic [7:0]      RData, RamAddr, RamWData, RamRData;
  logic            RamRWn;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [7:0] mem [256];

  ram_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
    .Gnt(Gnt), .Done(Done), .RData(RData), .RamAddr(RamAddr),
    .RamWData(RamWData), .RamRWn(RamRWn), .RamRData(RamRData)
  );

  always #5 Clk = ~Clk;

  // single-port RAM, no reset, read data one cycle after the edge
  always @(posedge Clk) begin
    if (!RamRWn) mem[RamAddr] <= RamWData;
    RamRData <= mem[RamAddr];
  end

  // requester protocol: Req stays high while granted
  always @(negedge Clk) begin
    if (armed && !Rst)
      assert ((Gnt & ~Req) == 4'b0) else $error("protocol: Req low while granted");
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req = '0; Wr = '0; Addr = '0; WData = '0;
    tick(); tick();
    @(negedge Clk);
    checks += 6;
    if (Gnt !== 4'b0)      begin errors++; $display("FAIL rst_gnt got %b exp 0000", Gnt); end
    if (Done !== 4'b0)     begin errors++; $display("FAIL rst_done got %b exp 0000", Done); end
    if (RData !== 8'h00)   begin errors++; $display("FAIL rst_rdata got %h exp 00", RData); end
    if (RamRWn !== 1'b1)   begin errors++; $display("FAIL rst_rwn got %b exp 1", RamRWn); end
    if (RamAddr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", RamAddr); end
    if (RamWData !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h exp 00", RamWData); end
    tick(); Rst = 1'b0;
    armed = 1'b1;
  endtask

  task automatic test_single_read();
    mem[8'h10] = 8'hA5;
    tick(); Req = 4'b0010; Wr = 4'b0000; Addr[1] = 8'h10;
    @(negedge Clk);
    checks++;
    if (Gnt !== 4'b0) begin errors++; $display("FAIL rd_idle_gnt got %b exp 0000", Gnt); end
    tick(); @(negedge Clk);
    checks += 4;
    if (Gnt !== 4'b0010)   begin errors++; $display("FAIL rd_issue_gnt got %b exp 0010", Gnt); end
    if (Done !== 4'b0)     begin errors++; $display("FAIL rd_issue_done got %b exp 0000", Done); end
    if (RamAddr !== 8'h10) begin errors++; $display("FAIL rd_issue_addr got %h exp 10", RamAddr); end
    if (RamRWn !== 1'b1)   begin errors++; $display("FAIL rd_issue_rwn got %b exp 1", RamRWn); end
    tick(); @(negedge Clk);
    checks += 3;
    if (Gnt !== 4'b0010)  begin errors++; $display("FAIL rd_cmp_gnt got %b exp 0010", Gnt); end
    if (Done !== 4'b0010) begin errors++; $display("FAIL rd_cmp_done got %b exp 0010", Done); end
    if (RData !== 8'hA5)  begin errors++; $display("FAIL rd_cmp_rdata got %h exp a5", RData); end
    tick(); Req = '0;
    @(negedge Clk);
    checks += 2;
    if (Gnt !== 4'b0)  begin errors++; $display("FAIL rd_after_gnt got %b exp 0000", Gnt); end
    if (Done !== 4'b0) begin errors++; $display("FAIL rd_after_done got %b exp 0000", Done); end
  endtask

  task automatic test_write_read();
    int n;
    tick(); Req = 4'b0001; Wr = 4'b0001; Addr[0] = 8'h22; WData[0] = 8'h3C;
    n = 0; @(negedge Clk);
    while (Done !== 4'b0001 && n < 6) begin @(negedge Clk); n++; end
    checks++;
    if (n != 2) begin errors++; $display("FAIL wr_done_latency got %0d exp 2", n); end
    tick(); Req = '0; Wr = '0;
    tick(); Req = 4'b0100; Addr[2] = 8'h22;
    n = 0; @(negedge Clk);
    while (Done !== 4'b0100 && n < 6) begin @(negedge Clk); n++; end
    checks += 2;
    if (n != 2) begin errors++; $display("FAIL wr_rd_latency got %0d exp 2", n); end
    if (RData !== 8'h3C) begin errors++; $display("FAIL wr_rd_data got %h exp 3c", RData); end
    tick(); Req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    tick(); Rst = 1'b1;
    tick(); Rst = 1'b0; Req = 4'b1111; Wr = '0;
    Addr = {8'h03, 8'h02, 8'h01, 8'h00};
    @(negedge Clk);
    for (int k = 0; k < 8; k++) begin
      e = 4'(1 << (k % 4));
      @(negedge Clk);
      checks += 2;
      if (Gnt !== e)    begin errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, Gnt, e); end
      if (Done !== 4'b0) begin errors++; $display("FAIL rr_issue_done k=%0d got %b exp 0000", k, Done); end
      @(negedge Clk);
      checks++;
      if (Done !== e) begin errors++; $display("FAIL rr_done k=%0d got %b exp %b", k, Done, e); end
    end
    tick(); Rst = 1'b1; Req = '0;
    tick(); Rst = 1'b0;
  endtask

  task automatic test_back_to_back_same();
    Req = 4'b0100; Wr = 4'b0100; Addr[2] = 8'h30; WData[2] = 8'h5A;
    @(negedge Clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      checks += 2;
      if (RamRWn !== ((c % 3) == 1 ? 1'b0 : 1'b1))
        begin errors++; $display("FAIL same_rwn c=%0d got %b", c, RamRWn); end
      if (Done !== ((c % 3) == 2 ? 4'b0100 : 4'b0000))
        begin errors++; $display("FAIL same_done c=%0d got %b", c, Done); end
    end
    tick(); Rst = 1'b1; Req = '0; Wr = '0;
    tick(); Rst = 1'b0;
  endtask

  task automatic test_reset_complete();
    // requester 2 leaves ptr at 3 before the reset
    Req = 4'b0100; Wr = '0; Addr[2] = 8'h10;
    @(negedge Clk);
    tick(); @(negedge Clk);
    tick(); Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (Done !== 4'b0100) begin errors++; $display("FAIL rc_done_pre got %b exp 0100", Done); end
    tick(); Rst = 1'b0; Req = '0;
    @(negedge Clk);
    checks += 4;
    if (Gnt !== 4'b0)    begin errors++; $display("FAIL rc_gnt got %b exp 0000", Gnt); end
    if (Done !== 4'b0)   begin errors++; $display("FAIL rc_done got %b exp 0000", Done); end
    if (RData !== 8'h00) begin errors++; $display("FAIL rc_rdata got %h exp 00", RData); end
    if (RamRWn !== 1'b1) begin errors++; $display("FAIL rc_rwn got %b exp 1", RamRWn); end
    tick(); Req = 4'b1010; Addr[1] = 8'h11; Addr[3] = 8'h13;
    @(negedge Clk);
    tick(); @(negedge Clk);
    checks++;
    if (Gnt !== 4'b0010) begin errors++; $display("FAIL rc_first_gnt got %b exp 0010", Gnt); end
    tick(); @(negedge Clk);
    tick(); Req = 4'b1000; @(negedge Clk);
    checks++;
    if (Gnt !== 4'b1000) begin errors++; $display("FAIL rc_second_gnt got %b exp 1000", Gnt); end
    tick(); @(negedge Clk);
    tick(); Req = '0;
  endtask

  task automatic test_reset_issue();
    int n;
    mem[8'h05] = 8'h00;
    tick(); Req = 4'b0001; Wr = 4'b0001; Addr[0] = 8'h05; WData[0] = 8'h77;
    @(negedge Clk);
    tick(); Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (RamRWn !== 1'b0) begin errors++; $display("FAIL ri_rwn got %b exp 0", RamRWn); end
    tick(); Rst = 1'b0; Req = '0; Wr = '0;
    @(negedge Clk);
    checks += 2;
    if (Done !== 4'b0) begin errors++; $display("FAIL ri_done got %b exp 0000", Done); end
    if (Gnt !== 4'b0)  begin errors++; $display("FAIL ri_gnt got %b exp 0000", Gnt); end
    tick(); Req = 4'b0010; Addr[1] = 8'h05;
    n = 0; @(negedge Clk);
    while (Done !== 4'b0010 && n < 6) begin @(negedge Clk); n++; end
    checks += 2;
    if (n != 2) begin errors++; $display("FAIL ri_rd_latency got %0d exp 2", n); end
    if (RData !== 8'h77) begin errors++; $display("FAIL ri_rd_data got %h exp 77", RData); end
    tick(); Req = '0;
  endtask

  // Reference: each grant occupies cycles [g_cyc, g_cyc+1]; arbitration
  // happens when nothing is in flight or in the completion cycle (with
  // the finishing requester excluded).
  task automatic test_random();
    logic [7:0] shadow [256];
    logic [3:0] done_prev, elig, eg, ed;
    logic [7:0] g_addr, g_wdata, g_rd, er;
    bit         g_wr, in_flight, is_issue, is_done;
    int g_idx, g_cyc, ptr_m, win, j;
    g_idx = -1; g_cyc = 0; ptr_m = 0; done_prev = '0;
    g_addr = '0; g_wdata = '0; g_rd = '0; g_wr = 1'b0;
    for (int a = 0; a < 256; a++) shadow[a] = mem[a];
    tick(); Rst = 1'b1; Req = '0;
    tick(); Rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (Req[i]) begin
          if (done_prev[i]) begin
            if ($urandom_range(0, 2) == 0) Req[i] = 1'b0;
            else begin
              Wr[i] = 1'($urandom_range(0, 1));
              Addr[i] = 8'h40 + 8'($urandom_range(0, 7));
              WData[i] = 8'($urandom);
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          Req[i] = 1'b1;
          Wr[i] = 1'($urandom_range(0, 1));
          Addr[i] = 8'h40 + 8'($urandom_range(0, 7));
          WData[i] = 8'($urandom);
        end
      end
      @(negedge Clk);
      in_flight = (g_idx >= 0) && (cyc <= g_cyc + 1);
      is_issue  = (g_idx >= 0) && (cyc == g_cyc);
      is_done   = (g_idx >= 0) && (cyc == g_cyc + 1);
      eg = in_flight ? 4'(1 << g_idx) : 4'b0;
      ed = is_done ? eg : 4'b0;
      er = (is_done && !g_wr) ? g_rd : 8'h00;
      checks += 6;
      if (Gnt !== eg)   begin errors++; $display("FAIL rnd_gnt cyc=%0d got %b exp %b", cyc, Gnt, eg); end
      if (Done !== ed)  begin errors++; $display("FAIL rnd_done cyc=%0d got %b exp %b", cyc, Done, ed); end
      if (RData !== er) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, RData, er); end
      if (RamRWn !== !(is_issue && g_wr))
        begin errors++; $display("FAIL rnd_rwn cyc=%0d got %b", cyc, RamRWn); end
      if (RamAddr !== (is_issue ? g_addr : 8'h00))
        begin errors++; $display("FAIL rnd_addr cyc=%0d got %h", cyc, RamAddr); end
      if (RamWData !== (is_issue ? g_wdata : 8'h00))
        begin errors++; $display("FAIL rnd_wdata cyc=%0d got %h", cyc, RamWData); end
      if (!in_flight || is_done) begin
        elig = Req;
        if (is_done) elig[g_idx] = 1'b0;
        win = -1;
        for (int k = 0; k < 4; k++) begin
          j = (ptr_m + k) % 4;
          if (win < 0 && elig[j]) win = j;
        end
        if (win >= 0) begin
          g_idx = win; g_cyc = cyc + 1; ptr_m = (win + 1) % 4;
          g_wr = Wr[win]; g_addr = Addr[win]; g_wdata = WData[win];
          g_rd = shadow[g_addr];
          if (g_wr) shadow[g_addr] = g_wdata;
        end else begin
          g_idx = -1;
        end
      end
      done_prev = Done;
      tick();
    end
    Rst = 1'b1; Req = '0;
    tick(); Rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_back_to_back_same();
    test_reset_complete();
    test_reset_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
